reg_buf: RTL
============

# reg_buf

Parametrised successor to the single-stage 136-bit datapath input register. A DEPTH-entry, DATA_W-wide elastic buffer with valid/ready handshakes on both sides, an occupancy count, and hold-last-value output. It sits between the block that produces the 136-bit data words and the downstream consumer. It absorbs bursts that the single register could only overwrite.

## Interface
- DATA_W, 136, word width in bits
- DEPTH, 4, number of storage entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), occupancy count width (derived, not overridden)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  DATA_W  write word
- in_valid  input  1  write request; replaces the old load-flag
- in_ready  output  1  buffer can accept a word this cycle
- data_out  output  DATA_W  head word, or last popped word when empty
- out_valid  output  1  head word present
- out_ready  input  1  consumer takes head word this cycle
- count  output  CNT_W  current occupancy, 0..DEPTH

## Operation
- Push when in_valid & in_ready: data_in is written at wr_ptr, and wr_ptr = (wr_ptr+1) mod DEPTH.
- Pop when out_valid & out_ready: the head word is copied to last_q, and rd_ptr = (rd_ptr+1) mod DEPTH.
- count update: count+1 on push only, count-1 on pop only, unchanged on both or neither.
- in_ready = (count != DEPTH), derived combinationally from registered count only (no out_ready path).
- out_valid = (count != 0).
- data_out = mem[rd_ptr] when out_valid, else last_q.
- Simultaneous push and pop with 0 < count < DEPTH: both happen, count is unchanged, FIFO order is kept.
- Full with out_ready = 1: the pop happens; in_ready stays 0 in that cycle, and the word is accepted the next cycle.
- Empty with in_valid = 1: the word is written; out_valid rises the next cycle. There is no same-cycle bypass.
- Pointer wrap: wr_ptr and rd_ptr wrap DEPTH-1 → 0. full/empty are decided from count, never from pointer equality.
- Data integrity: words leave in exact arrival order, bit-exact across all DATA_W bits (including bits above 128).

## Timing
- Reset values:
  - count = 0, wr_ptr = 0, rd_ptr = 0, last_q = 0
  - out_valid = 0, in_ready = 1, data_out = 0
  - mem contents are not reset
- rst asserted mid-operation: all stored words are discarded at that edge. Push/pop requests in the reset cycle are ignored.
- Latency: a word pushed at edge k is visible on data_out with out_valid = 1 after edge k. One cycle write-to-read.
- Throughput: one push and one pop per cycle sustained.
- in_valid/data_in may change freely while in_ready = 0. The producer is not required to hold them stable.

## Configuration
- REG_BUF_DROP_EN defined:
  - in_ready is tied to 1.
  - A push attempted while count == DEPTH is discarded, and buffer state is unchanged.
  - Extra output drop_cnt (16 bits) increments per discarded word and saturates at 16'hFFFF. It resets to 0.
  - A simultaneous pop while full still happens; the incoming word is dropped that cycle.
- REG_BUF_DROP_EN undefined:
  - Back-pressure behaviour as described in Operation.
  - No drop_cnt port.

## Structure
- Shared package reg_buf_pkg holds:
  - default DATA_W (136)
  - default DEPTH
  - drop counter width/saturation constant
- Storage array, pointers, count and last_q live in the single module reg_buf. No sub-module is required.
- The pointer-increment-with-wrap is a local function, not a sub-module.

## Test plan
Defaults apply unless stated: DATA_W = 136, DEPTH = 4.
- Reset
  - Stimulus: rst = 1 for 2 cycles with in_valid = 1.
  - Required: count = 0, out_valid = 0, in_ready = 1, data_out = 0 after release.
- Burst fill
  - Stimulus: push 136'h0123456789abcdef0123456789abcdef, 136'hfedcba9876543210fedcba9876543210, 136'h0f0f…0f, 136'hf0f0…f0 with out_ready = 0.
  - Required: count steps 1..4, then in_ready = 0, and a fifth push is not accepted.
- Drain
  - Stimulus: out_ready = 1 for 4 cycles after the fill.
  - Required: the four words appear in order. Then out_valid = 0 and data_out holds 136'hf0f0…f0.
- Concurrent push/pop
  - Stimulus: with count = 2, hold in_valid = out_ready = 1 for 10 cycles using an incrementing pattern.
  - Required: count stays 2, output = input delayed by 2 words, and pointers wrap cleanly.
- Reset mid-stream
  - Stimulus: with count = 3, pulse rst for 1 cycle.
  - Required: count = 0, out_valid = 0. The next pushed word is the next one read.
- Drop mode (REG_BUF_DROP_EN)
  - Stimulus: fill 4 words, then push 3 more with out_ready = 0.
  - Required: drop_cnt = 3, and the drained contents equal the original 4 words.

Source files
------------

// File: rtl/reg_buf_pkg.sv
// Shared constants for the reg_buf elastic buffer: default geometry and the
// drop-counter width/saturation value used when REG_BUF_DROP_EN is defined.
package reg_buf_pkg;
  localparam int DATA_W_DEF = 136;
  localparam int DEPTH_DEF  = 4;
  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/reg_buf.sv
// DEPTH-entry valid/ready elastic buffer with occupancy count and hold-last-value output.
// Optional macro REG_BUF_DROP_EN: never back-pressures, discards pushes while full and counts them.
module reg_buf
  import reg_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
`ifdef REG_BUF_DROP_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] last_q;
  logic              full;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full/empty come from the occupancy count only; pointers alias when full.
  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign data_out  = out_valid ? mem[rd_ptr] : last_q;

`ifdef REG_BUF_DROP_EN
  logic drop;
  assign in_ready = 1'b1;
  assign push     = in_valid & ~full;
  assign drop     = in_valid & full;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != DROP_CNT_MAX) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end
`else
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is left out of reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= data_in;
  end

endmodule
